// File: rtl/avmm_pkg.sv
// Shared types and default ROM contents for the Avalon-MM ROM responder.
package avmm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STALL,
    ACCEPT,
    LAT,
    RESP
  } state_t;

  // Width of the shared stall/latency down-counter.
  localparam int CNT_W = 16;

  // Default byte j of word i: 8*i + j + 1, wrapping at 256.
  function automatic logic [7:0] avmm_default_byte(input int i, input int j);
    int v;
    v = 8 * i + j + 1;
    return v[7:0];
  endfunction

  // Default 64-bit word for index i, byte 0 in the least significant lane.
  function automatic logic [63:0] avmm_default_word(input int i);
    logic [63:0] w;
    w = '0;
    for (int j = 0; j < 8; j++) begin
      w[8*j +: 8] = avmm_default_byte(i, j);
    end
    return w;
  endfunction

endpackage

// File: rtl/avmm_rom.sv
// Synchronous-read ROM (DEPTH x DATA_WIDTH) whose output register doubles as
// the responder's readdata register: it loads only when enabled and can be
// forced to zero for out-of-range reads.
module avmm_rom
  import avmm_pkg::*;
#(
  parameter int    DATA_WIDTH = 64,
  parameter int    DEPTH      = 16,
  parameter int    AW         = 4,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_en,
  input  logic                  i_zero,
  input  logic [AW-1:0]         i_addr,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_data;

  // Contents are the constant byte pattern from the package.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      for (int j = 0; j < DATA_WIDTH / 8; j++) begin
        r_mem[k][8*j +: 8] = avmm_default_byte(k, j);
      end
    end
  end

  // Registered read port; holds its value between enabled reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (i_en) begin
      r_data <= i_zero ? '0 : r_mem[i_addr];
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/avmm_rom_responder.sv
// Avalon-MM read-only responder: programmable waitrequest stall, fixed read
// latency, one outstanding read. Out-of-range addresses return zero data.
module avmm_rom_responder
  import avmm_pkg::*;
#(
  parameter int    DATA_WIDTH   = 64,
  parameter int    DEPTH        = 16,
  parameter int    WAIT_CYCLES  = 2,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = ""
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           address,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] readdata,
  output logic                  readdatavalid,
  output logic                  waitrequest
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [31:0]         r_addr;
  logic                r_waitrequest;
  logic                r_readdatavalid;

  logic [31:0]         w_rsp_addr;
  logic                w_in_range;
  logic                w_rom_en;
  logic [DATA_WIDTH-1:0] w_rom_data;

  // The ROM is read on the edge that enters RESP: straight from ACCEPT (live
  // address) when the latency is one cycle, otherwise from the end of LAT
  // (captured address).
  assign w_rsp_addr = (r_state == ACCEPT) ? address : r_addr;
  assign w_in_range = (w_rsp_addr < 32'(DEPTH));
  assign w_rom_en   = ((r_state == ACCEPT) && read && (READ_LATENCY == 1)) ||
                      ((r_state == LAT) && (r_cnt == '0));

  avmm_rom #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW),
    .INIT_FILE  (INIT_FILE)
  ) u_rom (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_rom_en),
    .i_zero (!w_in_range),
    .i_addr (w_rsp_addr[AW-1:0]),
    .o_data (w_rom_data)
  );

  // Handshake FSM with registered waitrequest/readdatavalid; one counter is
  // shared by the stall and latency phases since they never overlap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_addr          <= '0;
      r_waitrequest   <= 1'b1;
      r_readdatavalid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_readdatavalid <= 1'b0;
          if (read) begin
            if (WAIT_CYCLES == 0) begin
              r_state       <= ACCEPT;
              r_waitrequest <= 1'b0;
            end else begin
              r_state       <= STALL;
              r_cnt         <= CNT_W'(WAIT_CYCLES - 1);
              r_waitrequest <= 1'b1;
            end
          end else begin
            r_waitrequest <= 1'b1;
          end
        end
        STALL: begin
          if (!read) begin
            r_state       <= IDLE;
            r_waitrequest <= 1'b1;
          end else if (r_cnt == '0) begin
            r_state       <= ACCEPT;
            r_waitrequest <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ACCEPT: begin
          r_waitrequest <= 1'b1;
          if (read) begin
            r_addr <= address;
            if (READ_LATENCY == 1) begin
              r_state         <= RESP;
              r_readdatavalid <= 1'b1;
            end else begin
              r_state <= LAT;
              r_cnt   <= CNT_W'(READ_LATENCY - 2);
            end
          end else begin
            r_state <= IDLE;
          end
        end
        LAT: begin
          if (r_cnt == '0) begin
            r_state         <= RESP;
            r_readdatavalid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          r_state         <= IDLE;
          r_readdatavalid <= 1'b0;
          r_waitrequest   <= 1'b1;
        end
        default: begin
          r_state         <= IDLE;
          r_readdatavalid <= 1'b0;
          r_waitrequest   <= 1'b1;
        end
      endcase
    end
  end

  assign readdata      = w_rom_data;
  assign readdatavalid = r_readdatavalid;
  assign waitrequest   = r_waitrequest;

endmodule

// File: tb/tb_avmm_rom_responder.sv
// Scoreboard bench for avmm_rom_responder: instance 0 uses the default
// parameters, instance 1 uses WAIT_CYCLES=0 / READ_LATENCY=3.
module tb_avmm_rom_responder;

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst_n [2];
  logic [31:0] addr  [2];
  logic        rd    [2];
  logic [63:0] rdata [2];
  logic        rdv   [2];
  logic        wreq  [2];

  exp_t        q0[$];
  exp_t        q1[$];
  logic [63:0] hold [2];
  int          cyc;
  int          n_checks;
  int          n_fail;

  avmm_rom_responder #(
    .DATA_WIDTH(64), .DEPTH(16), .WAIT_CYCLES(2), .READ_LATENCY(1), .INIT_FILE("")
  ) dut0 (
    .clk(clk), .rst_n(rst_n[0]), .address(addr[0]), .read(rd[0]),
    .readdata(rdata[0]), .readdatavalid(rdv[0]), .waitrequest(wreq[0])
  );

  avmm_rom_responder #(
    .DATA_WIDTH(64), .DEPTH(16), .WAIT_CYCLES(0), .READ_LATENCY(3), .INIT_FILE("")
  ) dut1 (
    .clk(clk), .rst_n(rst_n[1]), .address(addr[1]), .read(rd[1]),
    .readdata(rdata[1]), .readdatavalid(rdv[1]), .waitrequest(wreq[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wait_of(input int w);
    return (w == 0) ? 2 : 0;
  endfunction

  function automatic int lat_of(input int w);
    return (w == 0) ? 1 : 3;
  endfunction

  // Reference word: byte j of word a is 8*a+j+1 mod 256; out of range -> 0.
  function automatic logic [63:0] ref_word(input logic [31:0] a);
    logic [63:0] r;
    r = '0;
    if (a < 32'd16) begin
      for (int j = 0; j < 8; j++) begin
        r[8*j +: 8] = 8'((8 * int'(a) + j + 1) % 256);
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int w, input logic [63:0] d, input int c);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    if (w == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  function automatic int qsize(input int w);
    return (w == 0) ? q0.size() : q1.size();
  endfunction

  // Monitor: pop and compare on each readdatavalid; between pulses readdata
  // must hold the last delivered word.
  task automatic mon(input int w);
    exp_t e;
    if (!rst_n[w]) begin
      hold[w] = '0;
      return;
    end
    if (rdv[w]) begin
      if (qsize(w) == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rdv[%0d]: got pulse, expected none (cycle %0d)", w, cyc);
      end else begin
        if (w == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk($sformatf("rdata[%0d]", w), rdata[w], e.data);
        chk($sformatf("rdv_cycle[%0d]", w), 64'(cyc), 64'(e.cyc));
        hold[w] = e.data;
      end
    end else begin
      chk($sformatf("rdata_hold[%0d]", w), rdata[w], hold[w]);
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // One read: raise read at the start of cycle t0, hold until waitrequest is
  // low, then scramble the address to show the captured one is used.
  task automatic issue(input int w, input logic [31:0] a, input logic [63:0] expd);
    int  t0;
    bit  ok;
    @(posedge clk);
    #1;
    rd[w]   = 1'b1;
    addr[w] = a;
    t0      = cyc;
    push(w, expd, t0 + wait_of(w) + 1 + lat_of(w));
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!wreq[w]) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) chk($sformatf("accept_cycle[%0d]", w), 64'(cyc), 64'(t0 + wait_of(w) + 1));
    else    chk($sformatf("accept_timeout[%0d]", w), 64'(0), 64'(1));
    @(posedge clk);
    #1;
    rd[w]   = 1'b0;
    addr[w] = $urandom;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (qsize(w) == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk($sformatf("rsp_timeout[%0d]", w), 64'(qsize(w)), 64'(0));
  endtask

  initial begin
    logic [31:0] a;
    int          t0;
    bit          ok;
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    hold[0]  = '0;
    hold[1]  = '0;
    for (int w = 0; w < 2; w++) begin
      rst_n[w] = 1'b0;
      rd[w]    = 1'b0;
      addr[w]  = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // Idle after reset.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle_wreq", 64'(wreq[0]), 64'(1));
      chk("idle_rdv", 64'(rdv[0]), 64'(0));
      chk("idle_rdata", rdata[0], 64'h0);
    end

    // Directed reads on the default instance.
    issue(0, 32'd0, 64'h0807060504030201);
    issue(0, 32'd1, 64'h100F0E0D0C0B0A09);
    for (int i = 2; i < 7; i++) issue(0, 32'(i), ref_word(32'(i)));
    issue(0, 32'd7, 64'h403F3E3D3C3B3A39);
    issue(0, 32'd16, 64'h0);
    issue(0, 32'hFFFF_FFFF, 64'h0);

    // Randomized reads, mostly in range with some far out of range.
    for (int i = 0; i < 12; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 19));
      issue(0, a, ref_word(a));
    end

    // Read dropped during STALL: never accepted, never answered.
    @(posedge clk);
    #1;
    rd[0]   = 1'b1;
    addr[0] = 32'd5;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rd[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("drop_wreq", 64'(wreq[0]), 64'(1));
    end
    issue(0, 32'd9, ref_word(32'd9));

    // Zero-wait, three-cycle-latency instance.
    issue(1, 32'd1, 64'h100F0E0D0C0B0A09);

    // Reset asserted during LAT abandons the read.
    @(posedge clk);
    #1;
    rd[1]   = 1'b1;
    addr[1] = 32'd2;
    t0      = cyc;
    ok      = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!wreq[1]) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rst_test_accept", 64'(ok ? cyc : -1), 64'(t0 + 1));
    @(posedge clk);
    #1;
    rd[1] = 1'b0;
    #2;
    rst_n[1] = 1'b0;
    #1;
    chk("async_rst_wreq", 64'(wreq[1]), 64'(1));
    chk("async_rst_rdv", 64'(rdv[1]), 64'(0));
    chk("async_rst_rdata", rdata[1], 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n[1] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("post_rst_rdv", 64'(rdv[1]), 64'(0));
    end
    issue(1, 32'd3, ref_word(32'd3));

    for (int i = 0; i < 8; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 19));
      issue(1, a, ref_word(a));
    end

    repeat (5) @(negedge clk);
    chk("q0_empty", 64'(q0.size()), 64'(0));
    chk("q1_empty", 64'(q1.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
